wasm_bulk_mem_ctrl: RTL and testbench



---
 rtl/wasm_pkg.sv | 27 ++
 rtl/wasm_bulk_mem_ctrl_if.sv | 29 ++
 rtl/wasm_range_check.sv | 21 ++
 rtl/wasm_bulk_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_wasm_bulk_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wasm_pkg.sv
// Shared WebAssembly core types: traps, memory access ops and bulk-memory ops.
// Feature macro used by the bulk-memory sequencer: WASM_BULK_MEM_WIDE_EN.
package wasm_pkg;

    localparam int unsigned PAGE_SIZE = 65536;

    typedef enum logic [2:0] {
        TRAP_NONE          = 3'd0,
        TRAP_UNREACHABLE   = 3'd1,
        TRAP_OUT_OF_BOUNDS = 3'd2,
        TRAP_DIV_ZERO      = 3'd3
    } trap_t;

    typedef enum logic [3:0] {
        MEM_NONE      = 4'd0,
        MEM_LOAD_I8_U = 4'd1,
        MEM_LOAD_I64  = 4'd2,
        MEM_STORE_I8  = 4'd3,
        MEM_STORE_I64 = 4'd4
    } mem_op_t;

    typedef enum logic {
        BULK_FILL = 1'b0,
        BULK_COPY = 1'b1
    } bulk_op_t;

endpackage

// File: rtl/wasm_bulk_mem_ctrl_if.sv
// Memory-side port bundle between the bulk-memory sequencer and wasm_memory.
// master = sequencer, slave = memory.
interface wasm_bulk_mem_ctrl_if;
    import wasm_pkg::*;

    logic [31:0] mem_pages;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    mem_op_t     mem_rd_op;
    logic [63:0] mem_rd_data;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    mem_op_t     mem_wr_op;
    logic [63:0] mem_wr_data;
    trap_t       mem_trap;

    modport master (
        input  mem_pages, mem_rd_data, mem_trap,
        output mem_rd_en, mem_rd_addr, mem_rd_op,
        output mem_wr_en, mem_wr_addr, mem_wr_op, mem_wr_data
    );

    modport slave (
        output mem_pages, mem_rd_data, mem_trap,
        input  mem_rd_en, mem_rd_addr, mem_rd_op,
        input  mem_wr_en, mem_wr_addr, mem_wr_op, mem_wr_data
    );

endinterface

// File: rtl/wasm_range_check.sv
// In-bounds test for [addr, addr+len) against pages*PAGE_BYTES.
// 34-bit sums so a 32-bit wraparound still reads as out of bounds.
module wasm_range_check
    import wasm_pkg::*;
#(
    parameter int unsigned PAGE_BYTES = PAGE_SIZE
) (
    input  logic [31:0] addr,
    input  logic [31:0] len,
    input  logic [31:0] pages,
    output logic        ok
);

    logic [33:0] end_a;
    logic [33:0] limit;

    assign end_a = {2'b0, addr} + {2'b0, len};
    assign limit = {2'b0, pages} * 34'(PAGE_BYTES);
    assign ok    = (end_a <= limit);

endmodule

// File: rtl/wasm_bulk_mem_ctrl.sv
// memory.fill / memory.copy sequencer: bounds check, then one transfer per cycle.
// WASM_BULK_MEM_WIDE_EN: move 8-byte chunks while at least 8 bytes remain.
module wasm_bulk_mem_ctrl
    import wasm_pkg::*;
#(
    parameter int unsigned PAGE_BYTES = PAGE_SIZE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  bulk_op_t    op,
    input  logic [31:0] dst,
    input  logic [31:0] src,
    input  logic [31:0] len,
    input  logic [7:0]  fill_val,
    output logic        busy,
    output logic        done,
    output trap_t       trap,
    wasm_bulk_mem_ctrl_if.master mem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_XFER,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    bulk_op_t    op_q, op_d;
    logic [31:0] dst_q, dst_d, src_q, src_d, len_q, len_d;
    logic [31:0] rem_q, rem_d, cur_q, cur_d;
    logic [7:0]  fill_q, fill_d;
    logic        back_q, back_d;
    trap_t       trap_q, trap_d;

    logic        dst_ok, src_ok, wide;
    logic [31:0] step, off;

    wasm_range_check #(.PAGE_BYTES(PAGE_BYTES)) u_dst_chk (
        .addr (dst_q),
        .len  (len_q),
        .pages(mem.mem_pages),
        .ok   (dst_ok)
    );

    wasm_range_check #(.PAGE_BYTES(PAGE_BYTES)) u_src_chk (
        .addr (src_q),
        .len  (len_q),
        .pages(mem.mem_pages),
        .ok   (src_ok)
    );

`ifdef WASM_BULK_MEM_WIDE_EN
    assign wide = (rem_q >= 32'd8);
`else
    assign wide = 1'b0;
`endif

    assign step = wide ? 32'd8 : 32'd1;
    // Backward chunk covers cur-7..cur so the cursor always names the top byte.
    assign off  = (back_q && wide) ? cur_q - 32'd7 : cur_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= BULK_FILL;
            dst_q   <= '0;
            src_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            cur_q   <= '0;
            fill_q  <= '0;
            back_q  <= 1'b0;
            trap_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            cur_q   <= cur_d;
            fill_q  <= fill_d;
            back_q  <= back_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_d   = src_q;
        len_d   = len_q;
        rem_d   = rem_q;
        cur_d   = cur_q;
        fill_d  = fill_q;
        back_d  = back_q;
        trap_d  = trap_q;

        mem.mem_rd_en   = 1'b0;
        mem.mem_rd_addr = '0;
        mem.mem_rd_op   = MEM_NONE;
        mem.mem_wr_en   = 1'b0;
        mem.mem_wr_addr = '0;
        mem.mem_wr_op   = MEM_NONE;
        mem.mem_wr_data = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    dst_d   = dst;
                    src_d   = src;
                    len_d   = len;
                    fill_d  = fill_val;
                    trap_d  = TRAP_NONE;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!dst_ok || (op_q == BULK_COPY && !src_ok)) begin
                    trap_d  = TRAP_OUT_OF_BOUNDS;
                    state_d = S_FIN;
                end else if (len_q == 32'd0) begin
                    state_d = S_FIN;
                end else begin
                    back_d  = (op_q == BULK_COPY) && (dst_q > src_q);
                    cur_d   = back_d ? len_q - 32'd1 : 32'd0;
                    rem_d   = len_q;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                mem.mem_wr_en   = !rst;
                mem.mem_wr_addr = dst_q + off;
                mem.mem_wr_op   = wide ? MEM_STORE_I64 : MEM_STORE_I8;
                if (op_q == BULK_COPY) begin
                    mem.mem_rd_en   = !rst;
                    mem.mem_rd_addr = src_q + off;
                    mem.mem_rd_op   = wide ? MEM_LOAD_I64 : MEM_LOAD_I8_U;
                    mem.mem_wr_data = wide ? mem.mem_rd_data
                                           : {56'b0, mem.mem_rd_data[7:0]};
                end else begin
                    mem.mem_wr_data = wide ? {8{fill_q}} : {56'b0, fill_q};
                end
                rem_d = rem_q - step;
                cur_d = back_q ? cur_q - step : cur_q + step;
                if (mem.mem_trap != TRAP_NONE) begin
                    trap_d  = mem.mem_trap;
                    state_d = S_FIN;
                end else if (rem_q == step) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FIN);
    assign trap = done ? trap_q : TRAP_NONE;

endmodule

// File: tb/tb_wasm_bulk_mem_ctrl.sv
// Directed bench for wasm_bulk_mem_ctrl with a behavioural byte memory.
// Works in both default and WASM_BULK_MEM_WIDE_EN builds.
module tb_wasm_bulk_mem_ctrl;
    import wasm_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    bulk_op_t    op;
    logic [31:0] dst, src, len;
    logic [7:0]  fill_val;
    logic        busy, done;
    trap_t       trap;

    logic [31:0] pages;
    logic        inj_en;
    logic [31:0] inj_addr;

    logic [7:0]  mem [0:65535];
    int          wr_cycles;
    int          wr_bytes;
    logic [31:0] trace [$];

    int n_cmp;
    int n_bad;

    wasm_bulk_mem_ctrl_if mif ();

    wasm_bulk_mem_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .dst     (dst),
        .src     (src),
        .len     (len),
        .fill_val(fill_val),
        .busy    (busy),
        .done    (done),
        .trap    (trap),
        .mem     (mif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mif.mem_pages = pages;
    assign mif.mem_trap  = (inj_en && mif.mem_wr_en && mif.mem_wr_addr == inj_addr)
                           ? TRAP_OUT_OF_BOUNDS : TRAP_NONE;

    always_comb begin
        mif.mem_rd_data = '0;
        if (mif.mem_rd_en) begin
            if (mif.mem_rd_op == MEM_LOAD_I64) begin
                for (int i = 0; i < 8; i++)
                    mif.mem_rd_data[8*i +: 8] = mem[16'(mif.mem_rd_addr + 32'(i))];
            end else begin
                mif.mem_rd_data[7:0] = mem[mif.mem_rd_addr[15:0]];
            end
        end
    end

    always @(posedge clk) begin
        if (mif.mem_wr_en && mif.mem_trap == TRAP_NONE) begin
            wr_cycles = wr_cycles + 1;
            trace.push_back(mif.mem_wr_addr);
            if (mif.mem_wr_op == MEM_STORE_I64) begin
                for (int i = 0; i < 8; i++)
                    mem[16'(mif.mem_wr_addr + 32'(i))] = mif.mem_wr_data[8*i +: 8];
                wr_bytes = wr_bytes + 8;
            end else begin
                mem[mif.mem_wr_addr[15:0]] = mif.mem_wr_data[7:0];
                wr_bytes = wr_bytes + 1;
            end
        end
    end

    // Issues one command; dcyc is the cycle (edge 0 = accept) where done is seen.
    task automatic run_cmd(input bulk_op_t o, input logic [31:0] d, s, l,
                           input logic [7:0] fv, output int dcyc,
                           output trap_t tr, output int nwr, output logic b1);
        int base;
        base = wr_cycles;
        dcyc = -1;
        tr   = TRAP_NONE;
        @(posedge clk); #1;
        start = 1'b1; op = o; dst = d; src = s; len = l; fill_val = fv;
        @(posedge clk); #1;
        start = 1'b0;
        b1 = busy;
        for (int k = 1; k <= 300; k++) begin
            if (done) begin
                dcyc = k;
                tr   = trap;
                break;
            end
            @(posedge clk); #1;
        end
        nwr = wr_cycles - base;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (trap !== TRAP_NONE) begin n_bad++; $display("FAIL reset_trap got %0d want 0", trap); end
        n_cmp++; if (mif.mem_wr_en !== 1'b0 || mif.mem_rd_en !== 1'b0) begin
            n_bad++; $display("FAIL reset_strobes got wr=%b rd=%b want 0", mif.mem_wr_en, mif.mem_rd_en);
        end
        n_cmp++; if (mif.mem_wr_addr !== 32'd0 || mif.mem_wr_data !== 64'd0) begin
            n_bad++; $display("FAIL reset_bus got a=%h d=%h want 0", mif.mem_wr_addr, mif.mem_wr_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        int dc, nw; trap_t tr; logic b1;
        mem[16'h00FF] = 8'h11;
        mem[16'h0105] = 8'h22;
        for (int i = 0; i < 5; i++) mem[16'h0100 + 16'(i)] = 8'h00;
        run_cmd(BULK_FILL, 32'h100, 32'h0, 32'd5, 8'hAB, dc, tr, nw, b1);
        n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL fill_busy_c1 got %b want 1", b1); end
        n_cmp++; if (dc != 7) begin n_bad++; $display("FAIL fill_latency got %0d want 7", dc); end
        n_cmp++; if (tr !== TRAP_NONE) begin n_bad++; $display("FAIL fill_trap got %0d want 0", tr); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (mem[16'h0100 + 16'(i)] !== 8'hAB) begin
                n_bad++; $display("FAIL fill_byte%0d got %h want ab", i, mem[16'h0100 + 16'(i)]);
            end
        end
        n_cmp++; if (mem[16'h00FF] !== 8'h11) begin n_bad++; $display("FAIL fill_below got %h want 11", mem[16'h00FF]); end
        n_cmp++; if (mem[16'h0105] !== 8'h22) begin n_bad++; $display("FAIL fill_above got %h want 22", mem[16'h0105]); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL fill_after got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_copy_fwd();
        int dc, nw; trap_t tr; logic b1;
        for (int i = 0; i < 4; i++) mem[16'h000C + 16'(i)] = 8'hEE;
        for (int i = 0; i < 8; i++) mem[16'h0010 + 16'(i)] = 8'(i);
        run_cmd(BULK_COPY, 32'h0C, 32'h10, 32'd8, 8'h00, dc, tr, nw, b1);
        n_cmp++; if (tr !== TRAP_NONE || dc < 0) begin n_bad++; $display("FAIL cfwd_done got trap=%0d cyc=%0d want 0", tr, dc); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (mem[16'h000C + 16'(i)] !== 8'(i)) begin
                n_bad++; $display("FAIL cfwd_byte%0d got %h want %h", i, mem[16'h000C + 16'(i)], 8'(i));
            end
        end
    endtask

    task automatic test_copy_bwd();
        int dc, nw, base; trap_t tr; logic b1;
        for (int i = 0; i < 8; i++) mem[16'h0010 + 16'(i)] = 8'(i);
        for (int i = 0; i < 4; i++) mem[16'h0018 + 16'(i)] = 8'hEE;
        base = trace.size();
        run_cmd(BULK_COPY, 32'h14, 32'h10, 32'd8, 8'h00, dc, tr, nw, b1);
        n_cmp++; if (tr !== TRAP_NONE || dc < 0) begin n_bad++; $display("FAIL cbwd_done got trap=%0d cyc=%0d want 0", tr, dc); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (mem[16'h0014 + 16'(i)] !== 8'(i)) begin
                n_bad++; $display("FAIL cbwd_byte%0d got %h want %h", i, mem[16'h0014 + 16'(i)], 8'(i));
            end
        end
`ifndef WASM_BULK_MEM_WIDE_EN
        n_cmp++; if (nw != 8) begin n_bad++; $display("FAIL cbwd_nwr got %0d want 8", nw); end
        for (int i = 0; i < 8 && base + i < trace.size(); i++) begin
            n_cmp++;
            if (trace[base + i] !== 32'h1B - 32'(i)) begin
                n_bad++; $display("FAIL cbwd_trace%0d got %h want %h", i, trace[base + i], 32'h1B - 32'(i));
            end
        end
`endif
    endtask

    task automatic test_oob();
        int dc, nw; trap_t tr; logic b1;
        run_cmd(BULK_FILL, 32'hFFFC, 32'h0, 32'd8, 8'h77, dc, tr, nw, b1);
        n_cmp++; if (dc != 2) begin n_bad++; $display("FAIL oob_latency got %0d want 2", dc); end
        n_cmp++; if (tr !== TRAP_OUT_OF_BOUNDS) begin n_bad++; $display("FAIL oob_trap got %0d want 2", tr); end
        n_cmp++; if (nw != 0) begin n_bad++; $display("FAIL oob_writes got %0d want 0", nw); end
        run_cmd(BULK_COPY, 32'h0, 32'hFFF0, 32'h20, 8'h00, dc, tr, nw, b1);
        n_cmp++; if (tr !== TRAP_OUT_OF_BOUNDS || nw != 0) begin
            n_bad++; $display("FAIL oob_src got trap=%0d nwr=%0d want 2 0", tr, nw);
        end
    endtask

    task automatic test_edges();
        int dc, nw; trap_t tr; logic b1;
        run_cmd(BULK_FILL, 32'h10000, 32'h0, 32'd0, 8'h33, dc, tr, nw, b1);
        n_cmp++; if (dc != 2 || tr !== TRAP_NONE) begin
            n_bad++; $display("FAIL len0 got cyc=%0d trap=%0d want 2 0", dc, tr);
        end
        n_cmp++; if (nw != 0) begin n_bad++; $display("FAIL len0_writes got %0d want 0", nw); end
        run_cmd(BULK_FILL, 32'hFFFFFFFF, 32'h0, 32'd2, 8'h33, dc, tr, nw, b1);
        n_cmp++; if (tr !== TRAP_OUT_OF_BOUNDS || nw != 0) begin
            n_bad++; $display("FAIL wrap got trap=%0d nwr=%0d want 2 0", tr, nw);
        end
    endtask

    task automatic test_mem_trap();
        int dc, nw; trap_t tr; logic b1;
        for (int i = 0; i < 6; i++) mem[16'h0200 + 16'(i)] = 8'h00;
        inj_en = 1'b1; inj_addr = 32'h202;
        run_cmd(BULK_FILL, 32'h200, 32'h0, 32'd6, 8'hC3, dc, tr, nw, b1);
        inj_en = 1'b0;
        n_cmp++; if (dc != 5) begin n_bad++; $display("FAIL mtrap_latency got %0d want 5", dc); end
        n_cmp++; if (tr !== TRAP_OUT_OF_BOUNDS) begin n_bad++; $display("FAIL mtrap_trap got %0d want 2", tr); end
        n_cmp++; if (mem[16'h0201] !== 8'hC3 || mem[16'h0202] !== 8'h00) begin
            n_bad++; $display("FAIL mtrap_bytes got %h %h want c3 00", mem[16'h0201], mem[16'h0202]);
        end
    endtask

    task automatic test_reset_mid();
        int base, dc, nw, want; trap_t tr; logic b1;
`ifdef WASM_BULK_MEM_WIDE_EN
        want = 9;
`else
        want = 2;
`endif
        base = wr_bytes;
        @(posedge clk); #1;
        start = 1'b1; op = BULK_FILL; dst = 32'h300; src = 0; len = 32'd10; fill_val = 8'h5A;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL rmid_idle got busy=%b done=%b want 0 0", busy, done);
        end
        n_cmp++; if (wr_bytes - base != want) begin
            n_bad++; $display("FAIL rmid_bytes got %0d want %0d", wr_bytes - base, want);
        end
        rst = 1'b0;
        run_cmd(BULK_FILL, 32'h310, 32'h0, 32'd3, 8'h66, dc, tr, nw, b1);
        n_cmp++; if (dc != 5 || tr !== TRAP_NONE) begin
            n_bad++; $display("FAIL rmid_next got cyc=%0d trap=%0d want 5 0", dc, tr);
        end
    endtask

    task automatic test_back_to_back();
        int dc, nw; trap_t tr; logic b1;
        run_cmd(BULK_FILL, 32'h400, 32'h0, 32'd1, 8'h01, dc, tr, nw, b1);
        run_cmd(BULK_FILL, 32'h401, 32'h0, 32'd2, 8'h02, dc, tr, nw, b1);
        n_cmp++; if (dc != 4 || nw != 2) begin
            n_bad++; $display("FAIL b2b got cyc=%0d nwr=%0d want 4 2", dc, nw);
        end
        n_cmp++; if (mem[16'h0400] !== 8'h01 || mem[16'h0402] !== 8'h02) begin
            n_bad++; $display("FAIL b2b_bytes got %h %h want 01 02", mem[16'h0400], mem[16'h0402]);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        wr_cycles = 0; wr_bytes = 0;
        start = 1'b0; op = BULK_FILL; dst = '0; src = '0; len = '0; fill_val = '0;
        pages = 32'd1; inj_en = 1'b0; inj_addr = '0;
        rst = 1'b1;
        test_reset();
        test_fill();
        test_copy_fwd();
        test_copy_bwd();
        test_oob();
        test_edges();
        test_mem_trap();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
